// File: rtl/neuron_sequencer.sv
// Single-neuron multiply-accumulate sequencer: streams len samples against stored
// weights, adds a bias, and presents the result saturated to 8 bits.
module neuron_sequencer #(
    parameter int N_MAX = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_addr,
    input  logic signed [7:0] cfg_wdata,
    input  logic              cfg_bias_we,
    input  logic              cfg_len_we,
    input  logic [4:0]        cfg_len,
    input  logic              in_valid,
    input  logic signed [7:0] in_x,
    output logic              in_ready,
    output logic              out_valid,
    output logic signed [7:0] out_y,
    input  logic              out_ready,
    output logic              busy
);

    localparam int IDX_W = (N_MAX > 1) ? $clog2(N_MAX) : 1;
    localparam int ACC_W = 20;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_BIAS, S_DONE} state_t;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [7:0]        out_y_q, out_y_d;
    logic                     out_valid_q, out_valid_d;
    logic                     in_ready_q, in_ready_d;
    logic                     busy_q, busy_d;
    logic signed [7:0]        w_q [N_MAX];
    logic signed [7:0]        w_d [N_MAX];
    logic signed [7:0]        bias_q, bias_d;
    logic [4:0]               len_q, len_d;

    logic                     accept;
    logic                     last;
    logic signed [15:0]       prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  sum;

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path infers a latch.
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        out_y_d     = out_y_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;
        w_d         = w_q;
        bias_d      = bias_q;
        len_d       = len_q;

        // Configuration is frozen for the whole evaluation; samples read the old values.
        if (!busy_q) begin
            if (cfg_we && int'(cfg_addr) < N_MAX)
                w_d[IDX_W'(cfg_addr)] = cfg_wdata;
            if (cfg_bias_we)
                bias_d = cfg_wdata;
            if (cfg_len_we && cfg_len != 5'd0 && int'(cfg_len) <= N_MAX)
                len_d = cfg_len;
        end

        accept   = in_valid && in_ready_q;
        prod     = in_x * w_q[idx_q];
        prod_ext = {{(ACC_W-16){prod[15]}}, prod};
        last     = (5'(idx_q) == len_q - 5'd1);
        sum      = acc_q + {{(ACC_W-8){bias_q[7]}}, bias_q};

        case (state_q)
            S_IDLE: begin
                acc_d = '0;
                idx_d = '0;
                if (accept) begin
                    acc_d  = prod_ext;
                    busy_d = 1'b1;
                    if (last) begin
                        state_d    = S_BIAS;
                        in_ready_d = 1'b0;
                    end else begin
                        state_d = S_ACCUM;
                        idx_d   = IDX_W'(1);
                    end
                end
            end
            S_ACCUM: begin
                if (accept) begin
                    acc_d = acc_q + prod_ext;
                    if (last) begin
                        state_d    = S_BIAS;
                        idx_d      = '0;
                        in_ready_d = 1'b0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_BIAS: begin
                acc_d       = sum;
                out_valid_d = 1'b1;
                state_d     = S_DONE;
                if (sum > 20'sd127)
                    out_y_d = 8'sd127;
                else if (sum < -20'sd128)
                    out_y_d = -8'sd128;
                else
                    out_y_d = sum[7:0];
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            out_y_q     <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            bias_q      <= '0;
            len_q       <= 5'(N_MAX);
            // NOTE: the weight store is reset because a cleared neuron must evaluate to bias alone.
            for (int i = 0; i < N_MAX; i++)
                w_q[i] <= '0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values.
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            out_y_q     <= out_y_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            bias_q      <= bias_d;
            len_q       <= len_d;
            w_q         <= w_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_neuron_sequencer.sv
// Directed self-checking bench for neuron_sequencer; expected results are hand-computed.
module tb_neuron_sequencer;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_we = 1'b0;
    logic [3:0]        cfg_addr = '0;
    logic signed [7:0] cfg_wdata = '0;
    logic              cfg_bias_we = 1'b0;
    logic              cfg_len_we = 1'b0;
    logic [4:0]        cfg_len = '0;
    logic              in_valid = 1'b0;
    logic signed [7:0] in_x = '0;
    logic              in_ready;
    logic              out_valid;
    logic signed [7:0] out_y;
    logic              out_ready = 1'b0;
    logic              busy;

    int n_cmp = 0;
    int n_bad = 0;

    neuron_sequencer #(.N_MAX(16)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_bias_we(cfg_bias_we), .cfg_len_we(cfg_len_we), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_x(in_x), .in_ready(in_ready),
        .out_valid(out_valid), .out_y(out_y), .out_ready(out_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_w(input int addr, input int val);
        cfg_addr  = 4'(addr);
        cfg_wdata = 8'(val);
        cfg_we    = 1'b1;
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic wr_bias(input int val);
        cfg_wdata   = 8'(val);
        cfg_bias_we = 1'b1;
        tick();
        cfg_bias_we = 1'b0;
    endtask

    task automatic wr_len(input int val);
        cfg_len    = 5'(val);
        cfg_len_we = 1'b1;
        tick();
        cfg_len_we = 1'b0;
    endtask

    // Present a sample and return just after the edge that accepts it.
    task automatic send(input int x);
        bit done = 0;
        in_valid = 1'b1;
        in_x     = 8'(x);
        for (int c = 0; c < 50 && !done; c++) begin
            if (in_ready) done = 1;
            tick();
        end
        if (!done) chk("accept_timeout", 0, 1);
    endtask

    // Called right after the last sample is accepted: BIAS cycle, then DONE and handshake.
    task automatic finish(input string tag, input int exp);
        in_valid = 1'b0;
        chk({tag, "_bias_ov"}, out_valid, 0);
        chk({tag, "_bias_rdy"}, in_ready, 0);
        tick();
        chk({tag, "_done_ov"}, out_valid, 1);
        chk({tag, "_y"}, out_y, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_ov_clr"}, out_valid, 0);
        chk({tag, "_idle_rdy"}, in_ready, 1);
        chk({tag, "_idle_busy"}, busy, 0);
    endtask

    initial begin
        int gaps [3] = '{3, 0, 2};

        // Reset state
        tick();
        chk("rst_rdy", in_ready, 1);
        chk("rst_ov", out_valid, 0);
        chk("rst_y", out_y, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        tick();

        // Basic frame: 20 - 3 - 8 + 5 = 14
        wr_len(3);
        wr_w(0, 2); wr_w(1, -3); wr_w(2, 4);
        wr_bias(5);
        send(10);
        chk("f1_busy", busy, 1);
        send(1);
        send(-2);
        finish("f1", 14);

        // Positive saturation: 2*127*127 + 127 = 32385
        wr_len(2);
        wr_w(0, 127); wr_w(1, 127); wr_bias(127);
        send(127); send(127);
        finish("sat_pos", 127);

        // Negative saturation: 2*127*(-128) - 128 = -32640
        wr_w(0, -128); wr_w(1, -128); wr_bias(-128);
        send(127); send(127);
        finish("sat_neg", -128);

        // Stalls between samples: 1+2+3+4 = 10
        wr_len(4);
        for (int i = 0; i < 4; i++) wr_w(i, 1);
        wr_bias(0);
        for (int i = 0; i < 4; i++) begin
            send(i + 1);
            if (i < 3) begin
                in_valid = 1'b0;
                for (int g = 0; g < gaps[i]; g++) begin
                    tick();
                    chk("gap_busy", busy, 1);
                    chk("gap_ov", out_valid, 0);
                end
            end
        end
        finish("gaps", 10);

        // DONE hold with writes while busy: 2*3 + 2*5 = 16
        wr_len(2);
        wr_w(0, 3); wr_w(1, 5);
        send(2); send(2);
        in_valid = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("hold_ov", out_valid, 1);
            chk("hold_y", out_y, 16);
            chk("hold_rdy", in_ready, 0);
            if (c == 1) wr_w(0, 100);
            else if (c == 2) wr_len(1);
            else if (c == 3) wr_bias(50);
            else tick();
        end
        chk("hold_end_y", out_y, 16);
        // A sample offered on the handshake edge must not be taken.
        in_valid  = 1'b1;
        in_x      = 8'sd1;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("hs_rdy", in_ready, 1);
        chk("hs_busy", busy, 0);
        // Illegal lengths ignored: len stays 2, weights 3,5, bias 0 -> 1*3 + 1*5 = 8
        in_valid = 1'b0;
        wr_len(0);
        wr_len(17);
        send(1); send(1);
        finish("busy_wr", 8);

        // Same-edge weight write and accept: the sample uses old w0=3 -> 3 + 5 = 8
        cfg_addr  = 4'd0;
        cfg_wdata = 8'sd50;
        cfg_we    = 1'b1;
        in_valid  = 1'b1;
        in_x      = 8'sd1;
        tick();
        cfg_we = 1'b0;
        send(1);
        finish("same_edge", 8);
        send(1); send(0);
        finish("new_w0", 50);

        // Reset mid-frame discards everything
        wr_len(4);
        for (int i = 0; i < 16; i++) wr_w(i, 1);
        wr_bias(3);
        send(5); send(6);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mrst_ov", out_valid, 0);
        chk("mrst_rdy", in_ready, 1);
        chk("mrst_busy", busy, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("mrst_ov2", out_valid, 0);

        // Default len 16 with cleared weights and bias -> 0
        for (int i = 0; i < 16; i++) begin
            send(i + 1);
            if (i == 3) chk("len16_rdy4", in_ready, 1);
            if (i == 14) chk("len16_rdy15", in_ready, 1);
        end
        finish("rst_clear", 0);

        // Fresh 16-sample frame: sum(-8..7) + 2 = -6
        for (int i = 0; i < 16; i++) wr_w(i, 1);
        wr_bias(2);
        for (int i = 0; i < 16; i++) send(i - 8);
        finish("len16", -6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
